// File: rtl/alu_reservation_station_pkg.sv
// Shared definitions for the ALU reservation station: sizing constants,
// the 5-bit ALU op encodings and the per-entry state record.
package alu_reservation_station_pkg;

  localparam int RS_SIZE    = 8;
  localparam int TAG_WIDTH  = 4;
  localparam int DATA_WIDTH = 32;

  // Bit 4 selects compare mode, bit 3 selects the SUB/SRA variant.
  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SLL  = 5'b00001,
    OP_SLT  = 5'b00010,
    OP_SLTU = 5'b00011,
    OP_XOR  = 5'b00100,
    OP_SRL  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_AND  = 5'b00111,
    OP_SUB  = 5'b01000,
    OP_SRA  = 5'b01101,
    OP_BEQ  = 5'b10000,
    OP_BNE  = 5'b10001,
    OP_BLT  = 5'b10100,
    OP_BGE  = 5'b10101,
    OP_BLTU = 5'b10110,
    OP_BGEU = 5'b10111
  } alu_op_e;

  // One reservation-station slot.
  typedef struct packed {
    logic                  busy;
    logic [4:0]            op;
    logic [DATA_WIDTH-1:0] vj;
    logic                  qj_pending;
    logic [TAG_WIDTH-1:0]  qj;
    logic [DATA_WIDTH-1:0] vk;
    logic                  qk_pending;
    logic [TAG_WIDTH-1:0]  qk;
    logic [TAG_WIDTH-1:0]  dest;
  } rs_entry_t;

  // True when a pending operand is satisfied by the current CDB broadcast.
  function automatic logic operand_wakes(
    input logic                 pending,
    input logic [TAG_WIDTH-1:0] q_tag,
    input logic                 cdb_valid,
    input logic [TAG_WIDTH-1:0] cdb_tag
  );
    return pending && cdb_valid && (q_tag == cdb_tag);
  endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatcher / CDB / ALU / result bundle around the reservation station.
// slave = the station itself, master = the surrounding pipeline.
interface alu_reservation_station_if #(
  parameter int TAG_WIDTH = alu_reservation_station_pkg::TAG_WIDTH
);

  logic                 issue_valid_in;
  logic [4:0]           issue_op_in;
  logic [31:0]          issue_vj_in;
  logic                 issue_qj_pending_in;
  logic [TAG_WIDTH-1:0] issue_qj_in;
  logic [31:0]          issue_vk_in;
  logic                 issue_qk_pending_in;
  logic [TAG_WIDTH-1:0] issue_qk_in;
  logic [TAG_WIDTH-1:0] issue_dest_in;
  logic                 full_out;

  logic                 cdb_valid_in;
  logic [TAG_WIDTH-1:0] cdb_tag_in;
  logic [31:0]          cdb_value_in;

  logic [31:0]          alu_a_out;
  logic [31:0]          alu_b_out;
  logic [4:0]           alu_op_out;
  logic [31:0]          alu_result_in;

  logic                 out_valid_out;
  logic [TAG_WIDTH-1:0] out_tag_out;
  logic [31:0]          out_value_out;

  modport slave (
    input  issue_valid_in, issue_op_in, issue_vj_in, issue_qj_pending_in,
           issue_qj_in, issue_vk_in, issue_qk_pending_in, issue_qk_in,
           issue_dest_in, cdb_valid_in, cdb_tag_in, cdb_value_in,
           alu_result_in,
    output full_out, alu_a_out, alu_b_out, alu_op_out,
           out_valid_out, out_tag_out, out_value_out
  );

  modport master (
    output issue_valid_in, issue_op_in, issue_vj_in, issue_qj_pending_in,
           issue_qj_in, issue_vk_in, issue_qk_pending_in, issue_qk_in,
           issue_dest_in, cdb_valid_in, cdb_tag_in, cdb_value_in,
           alu_result_in,
    input  full_out, alu_a_out, alu_b_out, alu_op_out,
           out_valid_out, out_tag_out, out_value_out
  );

endinterface

// File: rtl/alu_reservation_station_rs_priority_select.sv
// Lowest-index-first find-first-set over an N-bit request vector.
// Used both to pick the free slot for allocation and the ready entry to issue.
module rs_priority_select #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req_in,
  output logic                 valid_out,
  output logic [$clog2(N)-1:0] idx_out
);

  localparam int IDX_W = $clog2(N);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid_out = |req_in;
    idx_out   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx_out = req_in[i] ? IDX_W'(i) : idx_out;
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Out-of-order issue buffer in front of the shared integer ALU. Holds decoded
// micro-ops, snoops the CDB for missing operands, issues the lowest-index
// ready entry each cycle and registers the ALU result with its ROB tag.
module alu_reservation_station #(
  parameter int RS_SIZE   = alu_reservation_station_pkg::RS_SIZE,
  parameter int TAG_WIDTH = alu_reservation_station_pkg::TAG_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  alu_reservation_station_if.slave  rs_if
);

  import alu_reservation_station_pkg::*;

  localparam int IDX_W = $clog2(RS_SIZE);

  rs_entry_t            entries_q [RS_SIZE];
  rs_entry_t            entries_d [RS_SIZE];
  rs_entry_t            new_entry_s;

  logic [RS_SIZE-1:0]   free_vec_s;
  logic [RS_SIZE-1:0]   ready_vec_s;
  logic [RS_SIZE-1:0]   wake_j_s;
  logic [RS_SIZE-1:0]   wake_k_s;
  logic                 free_valid_s;
  logic [IDX_W-1:0]     free_idx_s;
  logic                 sel_valid_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic                 issue_wake_j_s;
  logic                 issue_wake_k_s;

  logic                 out_valid_q, out_valid_d;
  logic [TAG_WIDTH-1:0] out_tag_q,   out_tag_d;
  logic [31:0]          out_value_q, out_value_d;

  // Per-entry status: free slots, ready entries and CDB wake-up matches.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec_s[i]  = ~entries_q[i].busy;
      ready_vec_s[i] = entries_q[i].busy & ~entries_q[i].qj_pending
                       & ~entries_q[i].qk_pending;
      wake_j_s[i]    = entries_q[i].busy
                       & operand_wakes(entries_q[i].qj_pending, entries_q[i].qj,
                                       rs_if.cdb_valid_in, rs_if.cdb_tag_in);
      wake_k_s[i]    = entries_q[i].busy
                       & operand_wakes(entries_q[i].qk_pending, entries_q[i].qk,
                                       rs_if.cdb_valid_in, rs_if.cdb_tag_in);
    end
  end

  rs_priority_select #(.N(RS_SIZE)) u_free_select (
    .req_in    (free_vec_s),
    .valid_out (free_valid_s),
    .idx_out   (free_idx_s)
  );

  rs_priority_select #(.N(RS_SIZE)) u_ready_select (
    .req_in    (ready_vec_s),
    .valid_out (sel_valid_s),
    .idx_out   (sel_idx_s)
  );

  // Full ignores a same-cycle dispatch; the dispatcher sees a conservative view.
  assign rs_if.full_out = ~free_valid_s;

  // Build the incoming entry, snooping the CDB so a broadcast racing the
  // dispatch is not lost.
  always_comb begin
    issue_wake_j_s         = operand_wakes(rs_if.issue_qj_pending_in, rs_if.issue_qj_in,
                                           rs_if.cdb_valid_in, rs_if.cdb_tag_in);
    issue_wake_k_s         = operand_wakes(rs_if.issue_qk_pending_in, rs_if.issue_qk_in,
                                           rs_if.cdb_valid_in, rs_if.cdb_tag_in);
    new_entry_s.busy       = 1'b1;
    new_entry_s.op         = rs_if.issue_op_in;
    new_entry_s.vj         = issue_wake_j_s ? rs_if.cdb_value_in : rs_if.issue_vj_in;
    new_entry_s.qj_pending = rs_if.issue_qj_pending_in & ~issue_wake_j_s;
    new_entry_s.qj         = rs_if.issue_qj_in;
    new_entry_s.vk         = issue_wake_k_s ? rs_if.cdb_value_in : rs_if.issue_vk_in;
    new_entry_s.qk_pending = rs_if.issue_qk_pending_in & ~issue_wake_k_s;
    new_entry_s.qk         = rs_if.issue_qk_in;
    new_entry_s.dest       = rs_if.issue_dest_in;
  end

  // Drive the ALU from the selected entry, or all-zero when nothing is ready.
  always_comb begin
    if (sel_valid_s) begin
      rs_if.alu_a_out  = entries_q[sel_idx_s].vj;
      rs_if.alu_b_out  = entries_q[sel_idx_s].vk;
      rs_if.alu_op_out = entries_q[sel_idx_s].op;
    end else begin
      rs_if.alu_a_out  = 32'h0000_0000;
      rs_if.alu_b_out  = 32'h0000_0000;
      rs_if.alu_op_out = 5'b00000;
    end
  end

  // Next-state: stall holds, flush clears, otherwise wake-up, dispatch, issue.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      entries_d[i] = entries_q[i];
    end
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_value_d = out_value_q;

    if (!rdy_in) begin
      out_valid_d = out_valid_q;
    end else if (flush_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_d[i].busy = 1'b0;
      end
      out_valid_d = 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_d[i].vj         = wake_j_s[i] ? rs_if.cdb_value_in : entries_q[i].vj;
        entries_d[i].qj_pending = entries_q[i].qj_pending & ~wake_j_s[i];
        entries_d[i].vk         = wake_k_s[i] ? rs_if.cdb_value_in : entries_q[i].vk;
        entries_d[i].qk_pending = entries_q[i].qk_pending & ~wake_k_s[i];
      end

      if (sel_valid_s) begin
        entries_d[sel_idx_s].busy = 1'b0;
        out_valid_d               = 1'b1;
        out_tag_d                 = entries_q[sel_idx_s].dest;
        out_value_d               = rs_if.alu_result_in;
      end else begin
        out_valid_d = 1'b0;
      end

      // The free slot is never the dispatching one, so these never collide.
      entries_d[free_idx_s] = (rs_if.issue_valid_in && free_valid_s)
                              ? new_entry_s : entries_d[free_idx_s];
    end
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_value_q <= 32'h0000_0000;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= entries_d[i];
      end
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_value_q <= out_value_d;
    end
  end

  assign rs_if.out_valid_out = out_valid_q;
  assign rs_if.out_tag_out   = out_tag_q;
  assign rs_if.out_value_out = out_value_q;

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Out-of-order issue buffer and scheduler in front of the shared integer `arithmetic_logic_unit`.
- Holds up to RS_SIZE decoded ALU/compare micro-ops and snoops the common data bus (CDB) for missing operands.
- Each cycle it selects one ready entry, drives the ALU's a/b/op, and registers the result with its ROB tag for broadcast on the CDB.
- Sits between the dispatcher (issue side) and the CDB arbiter (result side).

Parameters:
- RS_SIZE, 8, number of entries; power of two, at least 2.
- TAG_WIDTH, 4, width of ROB tags used for dest/qj/qk.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  global ready; when low, state and outputs hold.
- flush_in  input  1  mispredict flush; clears all entries.
- issue_valid_in  input  1  new micro-op present.
- issue_op_in  input  5  ALU op code; bit4 selects compare mode, bit3 selects SUB/SRA.
- issue_vj_in  input  32  operand j value (meaningful when not pending).
- issue_qj_pending_in  input  1  operand j waits for a tag.
- issue_qj_in  input  TAG_WIDTH  producer tag for j.
- issue_vk_in  input  32  operand k value.
- issue_qk_pending_in  input  1  operand k waits for a tag.
- issue_qk_in  input  TAG_WIDTH  producer tag for k.
- issue_dest_in  input  TAG_WIDTH  ROB tag of this micro-op.
- full_out  output  1  no free entry this cycle.
- cdb_valid_in  input  1  CDB broadcast valid.
- cdb_tag_in  input  TAG_WIDTH  broadcast tag.
- cdb_value_in  input  32  broadcast value.
- alu_a_out  output  32  to ALU a.
- alu_b_out  output  32  to ALU b.
- alu_op_out  output  5  to ALU op.
- alu_result_in  input  32  from ALU result (combinational).
- out_valid_out  output  1  result valid this cycle (one-cycle pulse per micro-op).
- out_tag_out  output  TAG_WIDTH  ROB tag of result.
- out_value_out  output  32  result value.

Behaviour:
- **Reset:** all entries not busy; out_valid_out=0, out_tag_out=0, out_value_out=0. full_out=0 follows from empty state. alu_*_out are 0 when nothing is selected.
- **Entry state:** busy, op, vj, qj_pending, qj, vk, qk_pending, qk, dest. An entry is ready when busy and neither operand is pending.
- **full_out:** combinational; 1 iff all RS_SIZE entries are busy. It does not account for a same-cycle dispatch. The dispatcher must not assert issue_valid_in while full_out=1; if it does, the issue is silently dropped.
- **Issue:** on an edge with rdy_in=1, flush_in=0, issue_valid_in=1 and full_out=0, write the lowest-index free entry.
- **Issue-cycle snoop:** if an incoming operand is pending and cdb_valid_in=1 with cdb_tag_in equal to its q tag in the same cycle, store cdb_value_in and clear pending. No operand may be lost between dispatch and allocation.
- **Wake-up:** every edge with rdy_in=1, each busy entry with a pending operand whose tag matches a valid CDB broadcast captures the value and clears pending. Both operands may wake in the same cycle.
- **Select:** combinational; the lowest-index ready entry wins. If none is ready, drive alu_a_out/alu_b_out/alu_op_out = 0.
- **Dispatch:** on the next edge (rdy_in=1, flush_in=0) the winner's busy is cleared and the registered outputs update:
  - out_valid_out=1
  - out_tag_out = winner dest
  - out_value_out = alu_result_in
- **Latency:** an entry issued with both operands present at edge t is selectable in cycle t and produces out_valid_out after edge t+1. Minimum issue-to-result latency is 1 cycle.
- **No ready entry:** out_valid_out=0 after the edge; tag and value hold their last values.
- **Same-edge wake-up and select:** an entry woken at edge t becomes selectable only after that edge (no same-cycle bypass into the ALU).
- **Freed-slot reuse:** a slot freed by dispatch at edge t may be allocated by issue from edge t+1 onward.
- **rdy_in=0:** no state change. out_valid_out holds its value, and the downstream side must qualify it with rdy_in.
- **flush_in=1 (with rdy_in=1):** at the next edge, all busy bits clear and out_valid_out=0. A concurrent issue or dispatch is discarded. Flush has priority over everything except reset.
- **Asynchronous reset mid-operation:** everything clears immediately, regardless of clk_in.
- **Op pass-through:** alu_op_out is passed unmodified; compare results are 0/1 in bit 0.

Decomposition:
- **Shared package:** TAG_WIDTH, RS_SIZE, the 5-bit ALU op encodings (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, BEQ/BNE/BLT/BGE/BLTU/BGEU compare codes) and the RS entry struct typedef.
- **Sub-module:** `rs_priority_select`, a parameterised lowest-index-first find-first-set over a RS_SIZE-bit vector returning a valid flag plus index. It is used for both free-slot allocation and ready selection.

Test Plan:
- **Basic ADD:** issue ADD vj=5, vk=7, both present, dest=3, into an empty station → after the next edge out_valid_out=1, out_tag_out=3, out_value_out=12; full_out stays 0.
- **Wake-up:** issue SUB with qj pending on tag 6, vk=1, dest=2; three cycles later CDB sends tag=6, value=10 → result (tag 2, value 9) appears exactly one edge after the edge that captured the CDB value.
- **Issue-cycle snoop:** issue with qk pending on tag 4 while the CDB broadcasts tag 4, value 0x80000000, op SRA, vj=0xF0000000 → result 0xF0000000 appears with no extra wait.
- **Fill and drain:** issue 8 micro-ops all waiting on tag 1 → full_out=1 and a 9th issue is dropped. Broadcast tag 1 → 8 consecutive results in entry-index order; full_out drops on the first dispatch.
- **Flush:** with 5 busy entries and one ready, assert flush_in for one edge → no result is emitted, full_out=0, and a subsequent issue lands in entry 0.
- **Reset and stall:** hold rdy_in=0 while an entry is ready → no result and state frozen; pulse rst_in asynchronously mid-cycle → out_valid_out=0 immediately and all entries are free.
